// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared encodings for the SPI register-access front end
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    MSEL_SYS  = 2'd0,
    MSEL_IO   = 2'd1,
    MSEL_SMI  = 2'd2,
    MSEL_RSVD = 2'd3
  } msel_e;

  localparam int RW_BIT         = 7;
  localparam int RD_CAPTURE_DLY = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  // The reserved select still strobes but must not wake any module.
  function automatic logic [3:0] msel_onehot(input msel_e msel);
    case (msel)
      MSEL_SYS: return 4'b0001;
      MSEL_IO:  return 4'b0010;
      MSEL_SMI: return 4'b0100;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_if_if.sv
// rtl/spi_cmd_if_if.sv - register bus between the SPI decoder and the control modules
interface spi_cmd_if_if #(
  parameter int NUM_MOD = 4
) ();

  logic [4:0]           o_ioc;
  logic [7:0]           o_data_out;
  logic [NUM_MOD-1:0]   o_cs;
  logic                 o_fetch_cmd;
  logic                 o_load_cmd;
  logic [8*NUM_MOD-1:0] i_rd_data;

  modport master (
    output o_ioc,
    output o_data_out,
    output o_cs,
    output o_fetch_cmd,
    output o_load_cmd,
    input  i_rd_data
  );

  modport slave (
    input  o_ioc,
    input  o_data_out,
    input  o_cs,
    input  o_fetch_cmd,
    input  o_load_cmd,
    output i_rd_data
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall detect on the synced level
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_sys_clk,
  input  logic i_rst_b,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_rise = sync_q[STAGES-1] & ~prev_q;
  assign o_fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_cmd_if.sv
// rtl/spi_cmd_if.sv - SPI mode-0 slave decoding 2-byte frames into register bus strobes
module spi_cmd_if
  import spi_cmd_pkg::*;
#(
  parameter int NUM_MOD     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_sys_clk,
  input  logic         i_rst_b,
  input  logic         i_spi_sck,
  input  logic         i_spi_mosi,
  input  logic         i_spi_cs_b,
  output logic         o_spi_miso,
  output logic         o_spi_miso_oe,
  spi_cmd_if_if.master bus
);

  logic sck_rise, sck_fall, sck_sync_unused;
  logic cs_sync, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .i_async   (i_spi_sck),
    .o_sync    (sck_sync_unused),
    .o_rise    (sck_rise),
    .o_fall    (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .i_async   (i_spi_cs_b),
    .o_sync    (cs_sync),
    .o_rise    (cs_rise),
    .o_fall    (cs_fall)
  );

  logic [SYNC_STAGES-1:0]    mosi_q, mosi_d;
  logic [SYNC_STAGES-1:0]    live_q, live_d;
  logic                      armed_q, armed_d;
  state_e                    state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [6:0]                sh_q, sh_d;
  logic [4:0]                ioc_q, ioc_d;
  msel_e                     msel_q, msel_d;
  logic                      rw_q, rw_d;
  logic [7:0]                data_q, data_d;
  logic [NUM_MOD-1:0]        cs_q, cs_d;
  logic                      fetch_q, fetch_d;
  logic                      load_q, load_d;
  logic [RD_CAPTURE_DLY-1:0] fetch_dly_q, fetch_dly_d;
  logic [7:0]                miso_sh_q, miso_sh_d;
  logic [7:0]                rx_byte, rd_byte;

  // live_q marks when the CS_B chain holds real pin samples rather than its reset
  // value; a frame is only accepted once CS_B has been seen high after that.
  always_comb begin
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], i_spi_mosi};
    live_d      = {live_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (live_q[SYNC_STAGES-1] & cs_sync);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    ioc_d       = ioc_q;
    msel_d      = msel_q;
    rw_d        = rw_q;
    data_d      = data_q;
    cs_d        = '0;
    fetch_d     = 1'b0;
    load_d      = 1'b0;
    fetch_dly_d = {fetch_dly_q[RD_CAPTURE_DLY-2:0], fetch_q};
    miso_sh_d   = miso_sh_q;
    rx_byte     = {sh_q, mosi_q[SYNC_STAGES-1]};
    rd_byte     = (msel_q == MSEL_RSVD) ? 8'h00 : bus.i_rd_data[{msel_q, 3'b000} +: 8];

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 4'd0;
        if (cs_fall && armed_q) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          sh_d = rx_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            ioc_d     = rx_byte[4:0];
            msel_d    = msel_e'(rx_byte[6:5]);
            rw_d      = rx_byte[RW_BIT];
            state_d   = ST_DATA;
            if (!rx_byte[RW_BIT]) begin
              fetch_d = 1'b1;
              cs_d    = msel_onehot(msel_e'(rx_byte[6:5]));
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else begin
          // The fall closing byte0 arrives with bit_cnt 0 and must not shift out the MSB.
          if (!rw_q && fetch_dly_q[RD_CAPTURE_DLY-1]) begin
            miso_sh_d = rd_byte;
          end else if (!rw_q && sck_fall && bit_cnt_q != 4'd0) begin
            miso_sh_d = {miso_sh_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            sh_d = rx_byte[6:0];
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = ST_DONE;
              if (rw_q) begin
                data_d = rx_byte;
                load_d = 1'b1;
                cs_d   = msel_onehot(msel_q);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      ST_DONE: begin
        if (sck_rise && bit_cnt_q != 4'hF) bit_cnt_d = bit_cnt_q + 4'd1;
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_DATA) miso_sh_d = 8'h00;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      mosi_q      <= '0;
      live_q      <= '0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 4'd0;
      sh_q        <= 7'd0;
      ioc_q       <= 5'd0;
      msel_q      <= MSEL_SYS;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
      cs_q        <= '0;
      fetch_q     <= 1'b0;
      load_q      <= 1'b0;
      fetch_dly_q <= '0;
      miso_sh_q   <= 8'h00;
    end else begin
      mosi_q      <= mosi_d;
      live_q      <= live_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      ioc_q       <= ioc_d;
      msel_q      <= msel_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      fetch_q     <= fetch_d;
      load_q      <= load_d;
      fetch_dly_q <= fetch_dly_d;
      miso_sh_q   <= miso_sh_d;
    end
  end

  assign o_spi_miso      = miso_sh_q[7];
  assign o_spi_miso_oe   = ~cs_sync;
  assign bus.o_ioc       = ioc_q;
  assign bus.o_data_out  = data_q;
  assign bus.o_cs        = cs_q;
  assign bus.o_fetch_cmd = fetch_q;
  assign bus.o_load_cmd  = load_q;

endmodule

// File: tb/tb_spi_cmd_if.sv
// tb/tb_spi_cmd_if.sv - self-checking bench for spi_cmd_if
module tb_spi_cmd_if;

  localparam int HALF = 10;

  typedef struct {
    int          nbits;
    logic [31:0] frame;
    logic [31:0] rd;
    int          exp_fetch;
    int          exp_load;
    logic [3:0]  exp_cs;
    logic [4:0]  exp_ioc;
    logic [7:0]  exp_data;
    logic [7:0]  exp_miso;
    bit          chk_miso;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_b = 1'b1;
  logic        miso, miso_oe;
  logic [31:0] rd_data = 32'h0;

  spi_cmd_if_if #(.NUM_MOD(4)) bus ();
  assign bus.i_rd_data = rd_data;

  spi_cmd_if #(.NUM_MOD(4), .SYNC_STAGES(2)) dut (
    .i_sys_clk     (clk),
    .i_rst_b       (rst_b),
    .i_spi_sck     (sck),
    .i_spi_mosi    (mosi),
    .i_spi_cs_b    (cs_b),
    .o_spi_miso    (miso),
    .o_spi_miso_oe (miso_oe),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_fetch = 0, n_load = 0, n_both = 0, n_stray = 0;
  int         fetch_cyc = 0, load_cyc = 0;
  logic [3:0] fetch_cs = '0, load_cs = '0;
  logic [4:0] fetch_ioc = '0, load_ioc = '0;
  logic [7:0] load_data = '0;

  always @(negedge clk) begin
    if (rst_b) begin
      if (bus.o_fetch_cmd) begin
        n_fetch++; fetch_cs = bus.o_cs; fetch_ioc = bus.o_ioc; fetch_cyc = cyc;
      end
      if (bus.o_load_cmd) begin
        n_load++; load_cs = bus.o_cs; load_ioc = bus.o_ioc; load_data = bus.o_data_out; load_cyc = cyc;
      end
      if (bus.o_fetch_cmd && bus.o_load_cmd) n_both++;
      if (!bus.o_fetch_cmd && !bus.o_load_cmd && bus.o_cs != 4'b0) n_stray++;
    end
  end

  int    errors = 0, checks = 0;
  string cur_tag = "init";
  int    rise8_cyc = 0, rise16_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] frame, input int nbits, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[31-i];
      wait_clks(HALF);
      rx[31-i] = miso;
      sck = 1'b1;
      if (i == 7)  rise8_cyc  = cyc;
      if (i == 15) rise16_cyc = cyc;
      wait_clks(HALF);
      sck = 1'b0;
    end
  endtask

  // Frame-level expectations straight from the command byte layout.
  function automatic vec_t model(input logic [31:0] frame, input int nbits, input logic [31:0] rd);
    vec_t        v;
    logic [7:0]  cmd;
    logic [1:0]  msel;
    logic [31:0] sh;
    cmd  = frame[31:24];
    msel = cmd[6:5];
    sh   = rd >> (8 * msel);
    v.nbits     = nbits;
    v.frame     = frame;
    v.rd        = rd;
    v.exp_fetch = (nbits >= 8 && !cmd[7]) ? 1 : 0;
    v.exp_load  = (nbits >= 16 && cmd[7]) ? 1 : 0;
    v.exp_cs    = (msel == 2'd3) ? 4'b0000 : 4'(1 << msel);
    v.exp_ioc   = cmd[4:0];
    v.exp_data  = frame[23:16];
    v.exp_miso  = (msel == 2'd3) ? 8'h00 : sh[7:0];
    v.chk_miso  = (!cmd[7] && nbits >= 16);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int          f0, l0;
    logic [31:0] rx;
    rd_data = v.rd;
    f0 = n_fetch;
    l0 = n_load;
    cs_b = 1'b0;
    wait_clks(HALF);
    check("oe_active", 32'(miso_oe), 32'd1);
    spi_bits(v.frame, v.nbits, rx);
    wait_clks(HALF);
    cs_b = 1'b1;
    wait_clks(HALF);
    check("fetch_cnt", 32'(n_fetch - f0), 32'(v.exp_fetch));
    check("load_cnt", 32'(n_load - l0), 32'(v.exp_load));
    check("miso_byte0", 32'(rx[31:24]), 32'h0);
    check("oe_idle", 32'(miso_oe), 32'd0);
    if (v.exp_fetch != 0) begin
      check("fetch_cs", 32'(fetch_cs), 32'(v.exp_cs));
      check("fetch_ioc", 32'(fetch_ioc), 32'(v.exp_ioc));
      check("fetch_lat", 32'(fetch_cyc - rise8_cyc), 32'd3);
    end
    if (v.exp_load != 0) begin
      check("load_cs", 32'(load_cs), 32'(v.exp_cs));
      check("load_ioc", 32'(load_ioc), 32'(v.exp_ioc));
      check("load_data", 32'(load_data), 32'(v.exp_data));
      check("load_lat", 32'(load_cyc - rise16_cyc), 32'd3);
    end
    if (v.chk_miso) check("miso_byte1", 32'(rx[23:16]), 32'(v.exp_miso));
  endtask

  vec_t tbl[10];

  initial begin
    int          f0, l0;
    logic [31:0] rx;
    vec_t        rv;
    int          sel, nb;

    //            nbits frame          rd             fe ld cs       ioc    data   miso   chk
    tbl[0] = '{16, 32'h86A5_0000, 32'h0000_0000, 0, 1, 4'b0001, 5'd6,  8'hA5, 8'h00, 1'b0};
    tbl[1] = '{16, 32'h00FF_0000, 32'hEE33_2201, 1, 0, 4'b0001, 5'd0,  8'h00, 8'h01, 1'b1};
    tbl[2] = '{16, 32'h62FF_0000, 32'hEE33_2201, 1, 0, 4'b0000, 5'd2,  8'h00, 8'h00, 1'b1};
    tbl[3] = '{5,  32'h8600_0000, 32'h0000_0000, 0, 0, 4'b0000, 5'd0,  8'h00, 8'h00, 1'b0};
    tbl[4] = '{16, 32'hA13C_0000, 32'h0000_0000, 0, 1, 4'b0010, 5'd1,  8'h3C, 8'h00, 1'b0};
    tbl[5] = '{16, 32'h3F00_0000, 32'h1122_5AC3, 1, 0, 4'b0010, 5'd31, 8'h00, 8'h5A, 1'b1};
    tbl[6] = '{16, 32'hC481_0000, 32'h0000_0000, 0, 1, 4'b0100, 5'd4,  8'h81, 8'h00, 1'b0};
    tbl[7] = '{12, 32'h4100_0000, 32'h0096_0000, 1, 0, 4'b0100, 5'd1,  8'h00, 8'h00, 1'b0};
    tbl[8] = '{15, 32'h9F77_0000, 32'h0000_0000, 0, 0, 4'b0000, 5'd0,  8'h00, 8'h00, 1'b0};
    tbl[9] = '{32, 32'h8611_2233, 32'h0000_0000, 0, 1, 4'b0001, 5'd6,  8'h11, 8'h00, 1'b0};

    cur_tag = "reset";
    wait_clks(4);
    check("rst_ioc", 32'(bus.o_ioc), 32'h0);
    check("rst_data", 32'(bus.o_data_out), 32'h0);
    check("rst_cs", 32'(bus.o_cs), 32'h0);
    check("rst_fetch", 32'(bus.o_fetch_cmd), 32'h0);
    check("rst_load", 32'(bus.o_load_cmd), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_oe", 32'(miso_oe), 32'h0);
    rst_b = 1'b1;
    wait_clks(HALF);

    for (int i = 0; i < 10; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      apply(tbl[i]);
    end

    // Reset in the middle of a write: outputs clear immediately.
    cur_tag = "rst_mid";
    cs_b = 1'b0;
    wait_clks(HALF);
    spi_bits(32'h86A5_0000, 12, rx);
    rst_b = 1'b0;
    #1;
    check("ioc", 32'(bus.o_ioc), 32'h0);
    check("data", 32'(bus.o_data_out), 32'h0);
    check("cs", 32'(bus.o_cs), 32'h0);
    check("fetch", 32'(bus.o_fetch_cmd), 32'h0);
    check("load", 32'(bus.o_load_cmd), 32'h0);
    check("miso", 32'(miso), 32'h0);
    check("oe", 32'(miso_oe), 32'h0);
    wait_clks(4);
    rst_b = 1'b1;

    // CS_B held low through release: a full frame must be ignored.
    cur_tag = "rst_cs_low";
    f0 = n_fetch;
    l0 = n_load;
    wait_clks(HALF);
    check("oe_low_cs", 32'(miso_oe), 32'd1);
    spi_bits(32'hA13C_0000, 16, rx);
    spi_bits(32'h00FF_0000, 16, rx);
    wait_clks(HALF);
    cs_b = 1'b1;
    wait_clks(HALF);
    check("no_fetch", 32'(n_fetch - f0), 32'd0);
    check("no_load", 32'(n_load - l0), 32'd0);
    cur_tag = "after_cycle";
    apply(tbl[0]);

    for (int i = 0; i < 30; i++) begin
      cur_tag = $sformatf("rnd%0d", i);
      sel = $urandom_range(0, 5);
      if (sel <= 2)      nb = 16;
      else if (sel == 3) nb = 24;
      else if (sel == 4) nb = $urandom_range(1, 15);
      else               nb = 32;
      rv = model($urandom, nb, $urandom);
      apply(rv);
    end

    cur_tag = "global";
    check("strobes_together", 32'(n_both), 32'd0);
    check("cs_outside_strobe", 32'(n_stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
